fpcvt_arb: RTL and testbench

FPCVT_ARB -- requirements
Module: fpcvt_arb

---
 rtl/fpcvt_arb_if.sv | 26 ++
 rtl/fpcvt_arb.sv | 141 ++++++++++++++
 tb/tb_fpcvt_arb.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpcvt_arb_if.sv
// Request/result bus for fpcvt_arb: two requester handshakes plus the converted result port.
// master drives the requests and out_ready; slave is the arbiter side.
interface fpcvt_arb_if;
  logic        req_valid_a;
  logic [12:0] req_data_a;
  logic        req_ready_a;
  logic        req_valid_b;
  logic [12:0] req_data_b;
  logic        req_ready_b;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [4:0]  out_f;
  logic        out_src;

  modport master (
    output req_valid_a, req_data_a, req_valid_b, req_data_b, out_ready,
    input  req_ready_a, req_ready_b, out_valid, out_s, out_e, out_f, out_src
  );

  modport slave (
    input  req_valid_a, req_data_a, req_valid_b, req_data_b, out_ready,
    output req_ready_a, req_ready_b, out_valid, out_s, out_e, out_f, out_src
  );
endinterface

// File: rtl/fpcvt_arb.sv
// Round-robin arbiter sharing one 13-bit two's complement to (s, e[2:0], f[4:0]) converter
// between requesters A and B. Defining FPCVT_ARB_STATS_EN adds the conv_cnt handshake counter.
module fpcvt_arb (
  input  logic        clk,
  input  logic        rst,
  fpcvt_arb_if.slave  bus
`ifdef FPCVT_ARB_STATS_EN
  ,
  output logic [7:0]  conv_cnt
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, OUT = 2'd2} state_t;

  state_t      r_state;
  logic [12:0] r_sample;
  logic        r_last_b;
  logic        r_out_valid;
  logic        r_out_s;
  logic [2:0]  r_out_e;
  logic [4:0]  r_out_f;
  logic        r_out_src;

  logic w_grant_b;
  logic w_acc_a;
  logic w_acc_b;
  logic w_hs;

  // B wins only when it is alone or A was served last.
  assign w_grant_b = bus.req_valid_b & (~bus.req_valid_a | ~r_last_b);
  assign w_acc_a   = (r_state == IDLE) & bus.req_valid_a & ~w_grant_b;
  assign w_acc_b   = (r_state == IDLE) & bus.req_valid_b & w_grant_b;
  assign w_hs      = (r_state == OUT) & r_out_valid & bus.out_ready;

  logic [12:0] w_clamped;
  logic        w_neg;
  logic [12:0] w_mag;
  logic [3:0]  w_lz;
  logic [2:0]  w_exp_raw;
  logic [4:0]  w_win [8];
  logic [7:0]  w_rbit;
  logic [5:0]  w_sig_sum;
  logic [2:0]  w_cvt_e;
  logic [4:0]  w_cvt_f;

  // -4096 has no positive counterpart, so it is pulled in to -4095 first.
  assign w_clamped = (r_sample == 13'h1000) ? 13'h1001 : r_sample;
  assign w_neg     = w_clamped[12];
  assign w_mag     = w_neg ? (~w_clamped + 13'd1) : w_clamped;

  always_comb begin
    w_lz = 4'd13;
    for (int i = 0; i < 13; i++) begin
      if (w_mag[i]) w_lz = 4'(12 - i);
    end
  end

  assign w_exp_raw = (w_lz >= 4'd8) ? 3'd0 : 3'(4'd8 - w_lz);

  // One 5-bit window and guard bit per exponent; exponent 0 keeps the low bits unnormalised.
  for (genvar gi = 0; gi < 8; gi++) begin : g_win
    assign w_win[gi] = w_mag[gi+4:gi];
    if (gi == 0) begin : g_r0
      assign w_rbit[gi] = 1'b0;
    end else begin : g_rn
      assign w_rbit[gi] = w_mag[gi-1];
    end
  end

  assign w_sig_sum = {1'b0, w_win[w_exp_raw]} + {5'd0, w_rbit[w_exp_raw]};

  always_comb begin
    w_cvt_e = w_exp_raw;
    w_cvt_f = w_sig_sum[4:0];
    if (w_sig_sum[5]) begin
      if (w_exp_raw == 3'd7) begin
        w_cvt_f = 5'd31;
      end else begin
        w_cvt_e = w_exp_raw + 3'd1;
        w_cvt_f = 5'd16;
      end
    end
  end

  // r_last_b doubles as the source tag of the sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sample    <= '0;
      r_last_b    <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_s     <= 1'b0;
      r_out_e     <= '0;
      r_out_f     <= '0;
      r_out_src   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc_a | w_acc_b) begin
            r_sample <= w_acc_b ? bus.req_data_b : bus.req_data_a;
            r_last_b <= w_acc_b;
            r_state  <= CONV;
          end
        end
        CONV: begin
          r_out_s     <= w_neg;
          r_out_e     <= w_cvt_e;
          r_out_f     <= w_cvt_f;
          r_out_src   <= r_last_b;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_a = w_acc_a;
  assign bus.req_ready_b = w_acc_b;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_s       = r_out_s;
  assign bus.out_e       = r_out_e;
  assign bus.out_f       = r_out_f;
  assign bus.out_src     = r_out_src;

`ifdef FPCVT_ARB_STATS_EN
  logic [7:0] r_conv_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_conv_cnt <= '0;
    else if (w_hs) r_conv_cnt <= r_conv_cnt + 8'd1;
  end

  assign conv_cnt = r_conv_cnt;
`endif
endmodule

// File: tb/tb_fpcvt_arb.sv
// Bench for fpcvt_arb: conversion vector table, directed handshake/arbitration sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_fpcvt_arb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpcvt_arb_if bus();
`ifdef FPCVT_ARB_STATS_EN
  logic [7:0] conv_cnt;
`endif

  fpcvt_arb u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FPCVT_ARB_STATS_EN
    , .conv_cnt(conv_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [12:0] d;
    logic        s;
    logic [2:0]  e;
    logic [4:0]  f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] obs_out();
    return {bus.out_valid, bus.out_s, bus.out_e, bus.out_f, bus.out_src};
  endfunction

  function automatic logic [1:0] obs_rdy();
    return {bus.req_ready_a, bus.req_ready_b};
  endfunction

  function automatic logic [10:0] mk_out(input logic v, input logic s, input logic [2:0] e,
                                         input logic [4:0] f, input logic src);
    return {v, s, e, f, src};
  endfunction

  // Value-level conversion: locate the MSB, keep five bits from it, round on the next bit.
  function automatic logic [8:0] ref_conv(input logic [12:0] d);
    int v, m, p, e, f;
    logic s;
    v = int'($signed(d));
    if (v == -4096) v = -4095;
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 9'd0;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e = (p > 4) ? p - 4 : 0;
    f = m >> e;
    if (e > 0 && ((m >> (e - 1)) & 1) == 1) f++;
    if (f == 32) begin
      if (e == 7) f = 31;
      else begin
        e++;
        f = 16;
      end
    end
    return {s, 3'(e), 5'(f)};
  endfunction

  function automatic logic [12:0] rnd_data();
    logic [12:0] sp [6];
    sp = '{13'h0000, 13'h1000, 13'h0FFF, 13'h1FFF, 13'h0020, 13'h003F};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    return 13'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_a = 1'b0;
    bus.req_valid_b = 1'b0;
    bus.req_data_a  = '0;
    bus.req_data_b  = '0;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // A-only transaction with out_ready high; returns the observed result vector.
  task automatic run_a(input logic [12:0] d, output logic [10:0] got);
    int t;
    bus.out_ready   = 1'b1;
    bus.req_valid_a = 1'b1;
    bus.req_data_a  = d;
    #1;
    for (t = 0; t < 10; t++) begin
      if (bus.req_ready_a) break;
      tick();
    end
    chk("accept_wait", 32'(bus.req_ready_a), 32'd1);
    tick();
    bus.req_valid_a = 1'b0;
    for (t = 0; t < 10; t++) begin
      if (bus.out_valid) break;
      tick();
    end
    chk("result_wait", 32'(bus.out_valid), 32'd1);
    got = obs_out();
    $display("txn A data=0x%04h -> s=%0d e=%0d f=%0d src=%0d", d, got[9], got[8:6], got[5:1], got[0]);
    tick();
  endtask

  initial begin
    vec_t        vt [13];
    logic [10:0] got;
    logic [10:0] held;

    vt = '{
      '{13'd422,  1'b0, 3'd4, 5'd26},
      '{13'h0000, 1'b0, 3'd0, 5'd0},
      '{13'h0FFF, 1'b0, 3'd7, 5'd31},
      '{13'h1FFF, 1'b1, 3'd0, 5'd1},
      '{13'h1000, 1'b1, 3'd7, 5'd31},
      '{13'd31,   1'b0, 3'd0, 5'd31},
      '{13'd32,   1'b0, 3'd1, 5'd16},
      '{13'd63,   1'b0, 3'd2, 5'd16},
      '{13'd2047, 1'b0, 3'd7, 5'd16},
      '{13'h1F9C, 1'b1, 3'd2, 5'd25},
      '{13'd1000, 1'b0, 3'd5, 5'd31},
      '{13'd3000, 1'b0, 3'd7, 5'd23},
      '{13'd96,   1'b0, 3'd2, 5'd24}
    };

    // Reset state
    do_reset();
    chk("reset_out", 32'(obs_out()), 32'(mk_out(1'b0, 1'b0, 3'd0, 5'd0, 1'b0)));
    chk("reset_rdy", 32'(obs_rdy()), 32'd0);
`ifdef FPCVT_ARB_STATS_EN
    chk("reset_cnt", 32'(conv_cnt), 32'd0);
`endif

    // Conversion table through requester A
    for (int i = 0; i < 13; i++) begin
      run_a(vt[i].d, got);
      chk($sformatf("vec%0d", i), 32'(got), 32'(mk_out(1'b1, vt[i].s, vt[i].e, vt[i].f, 1'b0)));
    end

    // A only, 422: ready pulses once, result two cycles later
    do_reset();
    bus.out_ready = 1'b1;
    bus.req_valid_a = 1'b1;
    bus.req_data_a = 13'd422;
    #1;
    chk("s1_accept", 32'(obs_rdy()), 32'h2);
    tick();
    chk("s1_conv_rdy", 32'(obs_rdy()), 32'h0);
    chk("s1_conv_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("s1_result", 32'(obs_out()), 32'(mk_out(1'b1, 1'b0, 3'd4, 5'd26, 1'b0)));
    chk("s1_out_rdy", 32'(obs_rdy()), 32'h0);
    bus.req_valid_a = 1'b0;
    tick();
    chk("s1_done", 32'(bus.out_valid), 32'd0);
    $display("txn s1 A=422 done");

    // Both valid from reset: A first, then B
    do_reset();
    bus.out_ready = 1'b1;
    bus.req_valid_a = 1'b1; bus.req_data_a = 13'h0FFF;
    bus.req_valid_b = 1'b1; bus.req_data_b = 13'h1FFF;
    #1;
    chk("s2_first_grant", 32'(obs_rdy()), 32'h2);
    tick();
    bus.req_valid_a = 1'b0;
    #1;
    chk("s2_conv_rdy", 32'(obs_rdy()), 32'h0);
    tick();
    chk("s2_res_a", 32'(obs_out()), 32'(mk_out(1'b1, 1'b0, 3'd7, 5'd31, 1'b0)));
    tick();
    chk("s2_second_grant", 32'(obs_rdy()), 32'h1);
    tick();
    bus.req_valid_b = 1'b0;
    tick();
    chk("s2_res_b", 32'(obs_out()), 32'(mk_out(1'b1, 1'b1, 3'd0, 5'd1, 1'b1)));
    tick();
    $display("txn s2 A then B done");

    // Continuous contention: A,B,A,B one result every 3 cycles
    do_reset();
    bus.out_ready = 1'b1;
    bus.req_valid_a = 1'b1; bus.req_data_a = 13'd100;
    bus.req_valid_b = 1'b1; bus.req_data_b = 13'h1F9C;
    #1;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] er;
      er = 2'b00;
      if (k % 3 == 0) er = ((k / 3) % 2 == 0) ? 2'b10 : 2'b01;
      chk($sformatf("s3_rdy_c%0d", k), 32'(obs_rdy()), 32'(er));
      chk($sformatf("s3_valid_c%0d", k), 32'(bus.out_valid), 32'(k % 3 == 2));
      if (k % 3 == 2)
        chk($sformatf("s3_src_c%0d", k), 32'(bus.out_src), 32'((k / 3) % 2));
      tick();
    end
    bus.req_valid_a = 1'b0;
    bus.req_valid_b = 1'b0;
    $display("txn s3 alternation done");

    // -4096 with back-pressure: outputs held, no grants while busy
    do_reset();
    bus.req_valid_a = 1'b1; bus.req_data_a = 13'h1000;
    bus.req_valid_b = 1'b1; bus.req_data_b = 13'd5;
    #1;
    chk("s4_accept", 32'(obs_rdy()), 32'h2);
    tick();
    chk("s4_conv_rdy", 32'(obs_rdy()), 32'h0);
    bus.req_valid_a = 1'b0;
    tick();
    held = mk_out(1'b1, 1'b1, 3'd7, 5'd31, 1'b0);
    chk("s4_result", 32'(obs_out()), 32'(held));
    bus.req_valid_a = 1'b1; bus.req_data_a = 13'd3;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("s4_hold%0d", k), 32'(obs_out()), 32'(held));
      chk($sformatf("s4_hold_rdy%0d", k), 32'(obs_rdy()), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("s4_hs_rdy", 32'(obs_rdy()), 32'h0);
    tick();
    chk("s4_after_hs", 32'(bus.out_valid), 32'd0);
    chk("s4_next_grant", 32'(obs_rdy()), 32'h1);
    tick();
    bus.req_valid_a = 1'b0;
    bus.req_valid_b = 1'b0;
    tick();
    chk("s4_res_b", 32'(obs_out()), 32'(mk_out(1'b1, 1'b0, 3'd0, 5'd5, 1'b1)));
    tick();
    $display("txn s4 clamp/hold done");

    // Reset while busy
    do_reset();
    bus.req_valid_a = 1'b1; bus.req_data_a = 13'd7;
    bus.req_valid_b = 1'b1; bus.req_data_b = 13'd9;
    #1;
    chk("s5_accept", 32'(obs_rdy()), 32'h2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_valid_after_rst", 32'(bus.out_valid), 32'd0);
    chk("s5_a_wins", 32'(obs_rdy()), 32'h2);
    tick();
    tick();
    chk("s5_out_state", 32'(obs_out()), 32'(mk_out(1'b1, 1'b0, 3'd0, 5'd7, 1'b0)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_rst_in_out", 32'(obs_out()), 32'(mk_out(1'b0, 1'b0, 3'd0, 5'd0, 1'b0)));
    bus.req_valid_a = 1'b0;
    bus.req_valid_b = 1'b0;
    $display("txn s5 reset mid-flight done");

`ifdef FPCVT_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 256; k++) begin
      run_a(13'(k), got);
      if (k == 0) chk("cnt_first", 32'(conv_cnt), 32'd1);
      if (k == 254) chk("cnt_255", 32'(conv_cnt), 32'd255);
    end
    chk("cnt_wrap", 32'(conv_cnt), 32'd0);
`endif

    // Randomized run against the transaction-level model
    begin
      bit pa, pb, last_b, busy, ea, eb, ev;
      logic [12:0] da, db;
      logic [8:0] exp_res;
      bit exp_src;
      int acc_cyc;
      do_reset();
      pa = 0; pb = 0; last_b = 1; busy = 0; acc_cyc = 0;
      da = '0; db = '0; exp_res = '0; exp_src = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (!pa && $urandom_range(0, 2) != 0) begin pa = 1; da = rnd_data(); end
        if (!pb && $urandom_range(0, 2) != 0) begin pb = 1; db = rnd_data(); end
        bus.req_valid_a = pa; bus.req_data_a = da;
        bus.req_valid_b = pb; bus.req_data_b = db;
        bus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        ea = !busy && pa && (!pb || last_b);
        eb = !busy && pb && (!pa || !last_b);
        ev = busy && (cyc >= acc_cyc + 2);
        chk("rnd_rdy", 32'(obs_rdy()), 32'({ea, eb}));
        chk("rnd_valid", 32'(bus.out_valid), 32'(ev));
        if (ev) chk("rnd_result", 32'(obs_out()), 32'({1'b1, exp_res, exp_src}));
        if (ev && bus.out_ready) begin
          busy = 0;
          $display("txn rnd src=%0d s=%0d e=%0d f=%0d", exp_src, exp_res[8], exp_res[7:5], exp_res[4:0]);
        end
        if (ea || eb) begin
          busy = 1;
          acc_cyc = cyc;
          exp_src = eb;
          exp_res = ref_conv(eb ? db : da);
          last_b = eb;
          if (eb) pb = 0;
          else pa = 0;
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
